// File: rtl/memory_game_if.sv
// memory_game_if: player-input and display bundle between memory_game_engine and its surroundings
interface memory_game_if #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 32
);
  localparam int LW = $clog2(MAX_LEN + 1);
  logic             start;
  logic             play_again;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             show_valid;
  logic [SYM_W-1:0] show_sym;
  logic             await_input;
  logic [LW-1:0]    score;
  logic [LW-1:0]    round_len;
  logic             game_over;
  logic             win;
  logic             timed_out;
  modport slave (
    input  start, play_again, in_valid, in_sym,
    output show_valid, show_sym, await_input, score, round_len, game_over, win, timed_out
  );
  modport master (
    output start, play_again, in_valid, in_sym,
    input  show_valid, show_sym, await_input, score, round_len, game_over, win, timed_out
  );
endinterface

// File: rtl/memory_game_engine.sv
// memory_game_engine: Simon-style sequence store/replay/check core; define INPUT_TIMEOUT_EN to add an input idle timeout
module memory_game_engine #(
  parameter int          SYM_W          = 2,
  parameter int          MAX_LEN        = 32,
  parameter int          SHOW_CYCLES    = 8,
  parameter int          GAP_CYCLES     = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  memory_game_if.slave gif
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2((SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES) + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] EXTEND    = 3'd1;
  localparam logic [2:0] SHOW_ON   = 3'd2;
  localparam logic [2:0] SHOW_OFF  = 3'd3;
  localparam logic [2:0] INPUT     = 3'd4;
  localparam logic [2:0] GAME_OVER = 3'd5;
  localparam logic [2:0] WIN       = 3'd6;

  if (SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || LFSR_SEED == 16'h0) begin : g_bad_cfg
    $error("memory_game_engine: illegal parameter set");
  end

  logic [2:0]       state;
  logic [15:0]      lfsr;
  logic [LW-1:0]    len;
  logic [LW-1:0]    idx;
  logic [LW-1:0]    score;
  logic [CW-1:0]    cnt;
  logic             to;
  logic [SYM_W-1:0] mem [MAX_LEN];
  logic             last;
  logic             match;

  assign last  = idx == len - LW'(1);
  assign match = gif.in_sym == mem[idx[IW-1:0]];

  // Free-running so the moment start is pressed picks the sequence
  always_ff @(posedge clk)
    if (!rst && state == EXTEND) mem[len[IW-1:0]] <= lfsr[SYM_W-1:0];

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk)
    if (rst || state != INPUT || gif.in_valid) tcnt <= '0;
    else tcnt <= tcnt + TW'(1);
  wire idle_hit = state == INPUT && !gif.in_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  wire idle_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= LFSR_SEED;
      len   <= '0;
      idx   <= '0;
      score <= '0;
      cnt   <= '0;
      to    <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      case (state)
        IDLE: if (gif.start) begin
          state <= EXTEND;
          len   <= '0;
          score <= '0;
          to    <= 1'b0;
        end
        EXTEND: begin
          len   <= len + LW'(1);
          idx   <= '0;
          cnt   <= '0;
          state <= SHOW_ON;
        end
        SHOW_ON: begin
          cnt   <= cnt == CW'(SHOW_CYCLES - 1) ? '0 : cnt + CW'(1);
          state <= cnt == CW'(SHOW_CYCLES - 1) ? SHOW_OFF : SHOW_ON;
        end
        SHOW_OFF: begin
          cnt <= cnt == CW'(GAP_CYCLES - 1) ? '0 : cnt + CW'(1);
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            idx   <= last ? '0 : idx + LW'(1);
            state <= last ? INPUT : SHOW_ON;
          end
        end
        INPUT: begin
          if (gif.in_valid && !match) state <= GAME_OVER;
          else if (gif.in_valid && !last) idx <= idx + LW'(1);
          else if (gif.in_valid) begin
            score <= len;
            state <= len == LW'(MAX_LEN) ? WIN : EXTEND;
          end else if (idle_hit) begin
            state <= GAME_OVER;
            to    <= 1'b1;
          end
        end
        GAME_OVER, WIN: if (gif.play_again) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign gif.show_valid  = state == SHOW_ON;
  assign gif.show_sym    = state == SHOW_ON ? mem[idx[IW-1:0]] : '0;
  assign gif.await_input = state == INPUT;
  assign gif.score       = score;
  assign gif.round_len   = len;
  assign gif.game_over   = state == GAME_OVER;
  assign gif.win         = state == WIN;
  assign gif.timed_out   = to;
endmodule

// File: tb/tb_memory_game_engine.sv
// tb_memory_game_engine: scoreboard bench for memory_game_engine built with MAX_LEN=4
module tb_memory_game_engine;
  localparam int SYM_W = 2, MAX_LEN = 4, LW = 3, SHOW = 8, GAP = 4, TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_game_if #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN)) gif ();
  memory_game_engine #(
    .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO), .LFSR_SEED(16'hACE1)
  ) dut (.clk(clk), .rst(rst), .gif(gif));

  int checks = 0;
  int errors = 0;
  logic [15:0] m_lfsr;
  logic [SYM_W-1:0] seq [$];
  logic [SYM_W-1:0] exp_q [$];

  always @(posedge clk)
    m_lfsr <= rst ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic extend_push();
    seq.push_back(m_lfsr[SYM_W-1:0]);
    exp_q.delete();
    foreach (seq[j]) exp_q.push_back(seq[j]);
  endtask

  task automatic do_start(input bit pa);
    gif.start = 1'b1;
    gif.play_again = pa;
    tick();
    gif.start = 1'b0;
    gif.play_again = 1'b0;
    seq.delete();
    extend_push();
    checks++;
    if (gif.round_len !== '0 || gif.score !== '0 || gif.await_input !== 1'b0 || gif.timed_out !== 1'b0) begin
      errors++;
      $display("FAIL start_clear: len=%0d score=%0d await=%b to=%b, want 0 0 0 0",
               gif.round_len, gif.score, gif.await_input, gif.timed_out);
    end
  endtask

  task automatic show_round(input int n);
    int k;
    logic [SYM_W-1:0] e;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!gif.show_valid && k < 100) begin tick(); k++; end
      checks++;
      if (!gif.show_valid) begin
        errors++;
        $display("FAIL show_rise r%0d s%0d: show_valid=0 after %0d cycles, want 1", n, i, k);
        return;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL show_extra r%0d s%0d: got sym %0d, no symbol expected", n, i, gif.show_sym);
      end else begin
        e = exp_q.pop_front();
        if (gif.show_sym !== e) begin
          errors++;
          $display("FAIL show_sym r%0d s%0d: got %0d want %0d", n, i, gif.show_sym, e);
        end
      end
      checks++;
      if (gif.round_len !== LW'(n)) begin
        errors++;
        $display("FAIL round_len r%0d: got %0d want %0d", n, gif.round_len, n);
      end
      k = 0;
      while (gif.show_valid && k < 100) begin k++; tick(); end
      checks++;
      if (k != SHOW) begin
        errors++;
        $display("FAIL show_len r%0d s%0d: got %0d cycles want %0d", n, i, k, SHOW);
      end
      k = 0;
      while (!gif.show_valid && !gif.await_input && k < 100) begin k++; tick(); end
      checks++;
      if (k != GAP) begin
        errors++;
        $display("FAIL gap_len r%0d s%0d: got %0d cycles want %0d", n, i, k, GAP);
      end
    end
    checks++;
    if (gif.await_input !== 1'b1) begin
      errors++;
      $display("FAIL await_rise r%0d: got %b want 1", n, gif.await_input);
    end
  endtask

  task automatic enter_seq(input int n, input int bad);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gif.await_input !== 1'b1) begin
        errors++;
        $display("FAIL await_hold r%0d s%0d: got %b want 1", n, i, gif.await_input);
      end
      gif.in_valid = 1'b1;
      gif.in_sym = (i == bad) ? SYM_W'(seq[i] + 1) : seq[i];
      tick();
      gif.in_valid = 1'b0;
      if (i == bad) break;
    end
    if (bad < 0) begin
      checks++;
      if (gif.score !== LW'(n)) begin
        errors++;
        $display("FAIL score r%0d: got %0d want %0d", n, gif.score, n);
      end
      if (n < MAX_LEN) extend_push();
    end
  endtask

  task automatic test_reset();
    int highs;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({gif.show_valid, gif.show_sym, gif.await_input, gif.score, gif.round_len,
         gif.game_over, gif.win, gif.timed_out} !== '0) begin
      errors++;
      $display("FAIL reset_outs: sv=%b sym=%0d aw=%b sc=%0d len=%0d go=%b win=%b to=%b, want all 0",
               gif.show_valid, gif.show_sym, gif.await_input, gif.score, gif.round_len,
               gif.game_over, gif.win, gif.timed_out);
    end
    rst = 1'b0;
    highs = 0;
    repeat (20) begin tick(); if (gif.show_valid !== 1'b0) highs++; end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL idle_quiet: show_valid high %0d cycles, want 0", highs);
    end
  endtask

  task automatic test_rounds();
    do_start(1'b0);
    for (int r = 1; r <= MAX_LEN; r++) begin
      show_round(r);
      enter_seq(r, -1);
    end
    checks++;
    if (gif.win !== 1'b1 || gif.await_input !== 1'b0) begin
      errors++;
      $display("FAIL win: win=%b await=%b, want 1 0", gif.win, gif.await_input);
    end
    repeat (3) begin
      gif.in_valid = 1'b1;
      gif.in_sym = SYM_W'(seq[0] + 1);
      tick();
      gif.in_valid = 1'b0;
      tick();
    end
    checks++;
    if (gif.win !== 1'b1 || gif.score !== LW'(MAX_LEN) || gif.game_over !== 1'b0 || gif.show_valid !== 1'b0) begin
      errors++;
      $display("FAIL win_hold: win=%b score=%0d go=%b sv=%b, want 1 %0d 0 0",
               gif.win, gif.score, gif.game_over, gif.show_valid, MAX_LEN);
    end
    gif.play_again = 1'b1;
    tick();
    gif.play_again = 1'b0;
    checks++;
    if (gif.win !== 1'b0 || gif.game_over !== 1'b0 || gif.score !== LW'(MAX_LEN) || gif.round_len !== LW'(MAX_LEN)) begin
      errors++;
      $display("FAIL play_again_win: win=%b go=%b score=%0d len=%0d, want 0 0 %0d %0d",
               gif.win, gif.game_over, gif.score, gif.round_len, MAX_LEN, MAX_LEN);
    end
  endtask

  task automatic test_game_over();
    do_start(1'b1);
    show_round(1);
    enter_seq(1, -1);
    show_round(2);
    enter_seq(2, 1);
    checks++;
    if (gif.game_over !== 1'b1 || gif.score !== LW'(1) || gif.await_input !== 1'b0) begin
      errors++;
      $display("FAIL game_over: go=%b score=%0d await=%b, want 1 1 0", gif.game_over, gif.score, gif.await_input);
    end
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    checks++;
    if (gif.game_over !== 1'b1 || gif.round_len !== LW'(2)) begin
      errors++;
      $display("FAIL start_ignored: go=%b len=%0d, want 1 2", gif.game_over, gif.round_len);
    end
    gif.play_again = 1'b1;
    tick();
    gif.play_again = 1'b0;
    checks++;
    if ({gif.game_over, gif.win, gif.await_input, gif.show_valid, gif.timed_out} !== '0) begin
      errors++;
      $display("FAIL play_again_go: go=%b win=%b aw=%b sv=%b to=%b, want all 0",
               gif.game_over, gif.win, gif.await_input, gif.show_valid, gif.timed_out);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_start(1'b0);
    for (int r = 1; r <= 2; r++) begin
      show_round(r);
      enter_seq(r, -1);
    end
    k = 0;
    while (!gif.show_valid && k < 100) begin tick(); k++; end
    gif.in_valid = 1'b1;
    gif.in_sym = SYM_W'(seq[0] + 1);
    tick();
    gif.in_valid = 1'b0;
    checks++;
    if (gif.show_valid !== 1'b1 || gif.game_over !== 1'b0 || gif.round_len !== LW'(3)) begin
      errors++;
      $display("FAIL show_in_ignored: sv=%b go=%b len=%0d, want 1 0 3", gif.show_valid, gif.game_over, gif.round_len);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if ({gif.show_valid, gif.show_sym, gif.await_input, gif.score, gif.round_len,
         gif.game_over, gif.win, gif.timed_out} !== '0) begin
      errors++;
      $display("FAIL mid_reset: sv=%b sc=%0d len=%0d aw=%b, want all 0",
               gif.show_valid, gif.score, gif.round_len, gif.await_input);
    end
  endtask

  task automatic test_timeout();
    int k;
    do_start(1'b0);
    show_round(1);
`ifdef INPUT_TIMEOUT_EN
    k = 0;
    while (!gif.game_over && k < 100) begin tick(); k++; end
    checks++;
    if (k != TO || gif.timed_out !== 1'b1) begin
      errors++;
      $display("FAIL timeout: game_over after %0d cycles to=%b, want %0d and 1", k, gif.timed_out, TO);
    end
    gif.play_again = 1'b1;
    tick();
    gif.play_again = 1'b0;
    do_start(1'b0);
`else
    k = 0;
    repeat (1000) begin tick(); if (gif.await_input !== 1'b1) k++; end
    checks++;
    if (k != 0 || gif.game_over !== 1'b0 || gif.timed_out !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: left INPUT %0d cycles go=%b to=%b, want 0 0 0", k, gif.game_over, gif.timed_out);
    end
`endif
  endtask

  initial begin
    gif.start = 1'b0;
    gif.play_again = 1'b0;
    gif.in_valid = 1'b0;
    gif.in_sym = '0;
    test_reset();
    test_rounds();
    test_game_over();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
